// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: opcodes, controller states, and the flag word.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LSL = 3'd1,
    OP_XOR = 3'd2,
    OP_AND = 3'd3,
    OP_CMP = 3'd4,
    OP_SET = 3'd5,
    OP_LSR = 3'd6,
    OP_SUB = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic beven;
    logic parity;
    logic equal;
  } flags_t;

  localparam int FLAG_CARRY  = 4;
  localparam int FLAG_ZERO   = 3;
  localparam int FLAG_BEVEN  = 2;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_EQUAL  = 0;

  // Assemble a flag word by bit index so the layout lives in one place.
  function automatic flags_t pack_flags(input logic carry, input logic zero,
                                        input logic beven, input logic parity,
                                        input logic equal);
    logic [4:0] v;
    v              = '0;
    v[FLAG_CARRY]  = carry;
    v[FLAG_ZERO]   = zero;
    v[FLAG_BEVEN]  = beven;
    v[FLAG_PARITY] = parity;
    v[FLAG_EQUAL]  = equal;
    return flags_t'(v);
  endfunction

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/alu_seq_shift.sv
// Logical shifter for the ALU: either a one-bit-per-cycle walker or a single-cycle barrel.
// In both variants result_o/carry_o are the values to latch once busy_o is low:
// for the iterative walker that is the outcome of the step taken on the coming edge.
module alu_shift_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FAST_SHIFT = 0,
  parameter int CNT_W      = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dir_left_i,
  input  logic [CNT_W-1:0] amount_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  if (FAST_SHIFT != 0) begin : g_barrel
    logic [WIDTH:0] left_ext;
    logic [WIDTH:0] right_ext;
    logic           unused_seq;

    assign unused_seq = ^{clk_i, rst_ni, load_i};

    // One guard bit on each side catches the last bit pushed out, even for a full-width shift.
    always_comb begin
      left_ext  = {1'b0, data_i} << amount_i;
      right_ext = {data_i, 1'b0} >> amount_i;
    end

    assign result_o = dir_left_i ? left_ext[WIDTH-1:0] : right_ext[WIDTH:1];
    assign carry_o  = dir_left_i ? left_ext[WIDTH]     : right_ext[0];
    assign busy_o   = 1'b0;
  end else begin : g_iter
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;

    // Capture the operand on load, then step one bit per cycle until the count runs out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        work_q <= '0;
        cnt_q  <= '0;
        dir_q  <= 1'b0;
      end else if (load_i) begin
        work_q <= data_i;
        cnt_q  <= amount_i;
        dir_q  <= dir_left_i;
      end else if (cnt_q != '0) begin
        work_q <= result_o;
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end

    assign result_o = dir_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    assign carry_o  = dir_q ? work_q[WIDTH-1] : work_q[0];
    assign busy_o   = cnt_q > CNT_W'(1);
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides, carry-aware ADD/SUB,
// a latched flag word and an iterative or barrel shifter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FAST_SHIFT = 0,
  parameter int CNT_W      = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] arg_0,
  input  logic [WIDTH-1:0] arg_1,
  input  logic             use_carry,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [4:0]       flags
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  flags_t           flags_q, flags_d;
  logic             pend_parity_q, pend_parity_d;
  logic             pend_equal_q, pend_equal_d;

  alu_op_t          op;
  logic             accept;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [CNT_W-1:0] sh_amt;
  logic             sh_load;
  logic             sh_busy;
  logic [WIDTH-1:0] sh_result;
  logic             sh_carry;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;

  assign op       = alu_op_t'(alu_op);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign cin      = use_carry & carry_in;
  assign sum      = {1'b0, arg_0} + {1'b0, arg_1} + (WIDTH+1)'(cin);
  assign diff     = {1'b0, arg_0} - {1'b0, arg_1} - (WIDTH+1)'(cin);
  assign sh_amt   = (arg_1 >= WIDTH_V) ? WIDTH_C : arg_1[CNT_W-1:0];

  alu_shift_unit #(
    .WIDTH     (WIDTH),
    .FAST_SHIFT(FAST_SHIFT),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .load_i    (sh_load),
    .dir_left_i(op == OP_LSL),
    .amount_i  (sh_amt),
    .data_i    (arg_0),
    .busy_o    (sh_busy),
    .result_o  (sh_result),
    .carry_o   (sh_carry)
  );

  // Next state, result and flags: finish a pending shift, release on out_ready, start on accept.
  always_comb begin
    state_d       = state_q;
    alu_out_d     = alu_out_q;
    flags_d       = flags_q;
    pend_parity_d = pend_parity_q;
    pend_equal_d  = pend_equal_q;
    sh_load       = 1'b0;
    op_res        = '0;
    op_carry      = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (!sh_busy) begin
          alu_out_d = sh_result;
          flags_d   = pack_flags(sh_carry, sh_result == '0, ~sh_result[0],
                                 pend_parity_q, pend_equal_q);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d       = ST_DONE;
      pend_parity_d = ^arg_0;
      pend_equal_d  = (arg_0 == arg_1);

      unique case (op)
        OP_ADD: begin
          op_res   = sum[WIDTH-1:0];
          op_carry = sum[WIDTH];
        end
        OP_SUB: begin
          op_res   = diff[WIDTH-1:0];
          op_carry = ~diff[WIDTH];
        end
        OP_XOR: op_res = arg_0 ^ arg_1;
        OP_AND: op_res = arg_0 & arg_1;
        OP_SET: op_res = arg_1;
        OP_CMP: op_carry = (arg_0 >= arg_1);
        OP_LSL, OP_LSR: begin
          if (FAST_SHIFT != 0) begin
            op_res   = sh_result;
            op_carry = sh_carry;
          end else if (sh_amt == '0) begin
            op_res = arg_0;
          end else begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        default: ;
      endcase

      if (state_d == ST_DONE) begin
        alu_out_d = op_res;
        if (op == OP_CMP) begin
          flags_d = pack_flags(op_carry, arg_0 == arg_1, 1'b1, ^arg_0, arg_0 == arg_1);
        end else begin
          flags_d = pack_flags(op_carry, op_res == '0, ~op_res[0], ^arg_0, arg_0 == arg_1);
        end
      end
    end
  end

  // Controller state and the registered result/flags; reset discards any in-flight op.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      alu_out_q     <= '0;
      flags_q       <= '0;
      pend_parity_q <= 1'b0;
      pend_equal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_out_q     <= alu_out_d;
      flags_q       <= flags_d;
      pend_parity_q <= pend_parity_d;
      pend_equal_q  <= pend_equal_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign alu_out   = alu_out_q;
  assign flags     = flags_q;

endmodule
